// File: rtl/ws2812_strip.sv
// ws2812_strip
//   Drives a chain of WS2812-style LEDs from a double-buffered pixel store.
//   The host writes pixels into a back bank while the front bank is shifted
//   out; at the start of each frame the banks swap if anything was written.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high; restarts the latch gap
//   write       store led_data at led_num into the back bank
//   led_num     LED index for write (indices >= NUM_LEDS are ignored)
//   led_data    pixel value, MSB sent first
//   start       request one frame (used only when CONTINUOUS = 0)
//   data        registered serial line to the first LED
//   busy        high while a frame or its latch gap is in progress
//   frame_done  one-cycle pulse on the last cycle of a frame's latch gap
module ws2812_strip #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int CLK_MHZ      = 12,
  parameter int T1H_NS       = 900,
  parameter int T0H_NS       = 350,
  parameter int TBIT_NS      = 1250,
  parameter int TRES_US      = 280,
  parameter int CONTINUOUS   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [7:0]              led_num,
  input  logic [BITS_PER_LED-1:0] led_data,
  input  logic                    start,
  output logic                    data,
  output logic                    busy,
  output logic                    frame_done
);

  // Timing in clock cycles, rounded up so every pulse is at least as long
  // as its nominal duration.
  localparam int N1H   = (CLK_MHZ * T1H_NS + 999) / 1000;
  localparam int N0H   = (CLK_MHZ * T0H_NS + 999) / 1000;
  localparam int NBIT  = (CLK_MHZ * TBIT_NS + 999) / 1000;
  localparam int NRES  = CLK_MHZ * TRES_US;
  localparam int NMAX  = (NBIT > NRES) ? NBIT : NRES;
  localparam int CNT_W = $clog2(NMAX + 1);
  localparam int BIT_W = $clog2(BITS_PER_LED);
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t                  state_reg;
  logic [BITS_PER_LED-1:0] bank0_reg [NUM_LEDS];
  logic [BITS_PER_LED-1:0] bank1_reg [NUM_LEDS];
  logic                    sel_reg;     // bank currently being sent
  logic                    dirty_reg;   // back bank written since last swap
  logic [CNT_W-1:0]        cyc_reg;     // cycle within the current bit
  logic [CNT_W-1:0]        lat_reg;     // latch cycles remaining, incl. current
  logic [BIT_W-1:0]        bit_reg;     // bit index, counts down from MSB
  logic [LED_W-1:0]        led_reg;     // LED being sent
  logic                    data_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    frame_reg;   // latch gap belongs to a real frame

  // Write address decode; out-of-range indices match nothing.
  logic [NUM_LEDS-1:0] wr_hit;
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_wr_dec
    assign wr_hit[gi] = write && (led_num == 8'(gi));
  end

  logic wr_ok;
  logic go;
  logic swap;
  assign wr_ok = |wr_hit;
  assign go    = (state_reg == IDLE) && ((CONTINUOUS != 0) || start);
  // A write coinciding with frame start lands in the pre-swap back bank,
  // so it must force the swap to make it visible in this frame.
  assign swap  = go && (dirty_reg || wr_ok);

  logic [BITS_PER_LED-1:0] front_pixel;
  logic                    cur_bit;
  assign front_pixel = sel_reg ? bank1_reg[led_reg] : bank0_reg[led_reg];
  assign cur_bit     = front_pixel[bit_reg];

  logic             last_cyc;
  logic             last_bit;
  logic             last_led;
  logic [CNT_W-1:0] cyc_next;
  logic [CNT_W-1:0] high_len;
  logic             send_level;
  assign last_cyc   = (cyc_reg == CNT_W'(NBIT - 1));
  assign last_bit   = (bit_reg == '0);
  assign last_led   = (led_reg == LED_W'(NUM_LEDS - 1));
  assign cyc_next   = last_cyc ? '0 : cyc_reg + 1'b1;
  assign high_len   = cur_bit ? CNT_W'(N1H) : CNT_W'(N0H);
  // Every bit starts high, so the first cycle of a bit never needs the
  // pixel value; this also gives a frame-start write a cycle to land.
  assign send_level = (cyc_next == '0) || (cyc_next < high_len);

  // Pixel banks, bank select and dirty flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        bank0_reg[i] <= '0;
        bank1_reg[i] <= '0;
      end
      sel_reg   <= 1'b0;
      dirty_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_hit[i]) begin
          if (sel_reg) begin
            bank0_reg[i] <= led_data;
          end else begin
            bank1_reg[i] <= led_data;
          end
        end
      end
      if (swap) begin
        sel_reg   <= ~sel_reg;
        dirty_reg <= 1'b0;
      end else if (wr_ok) begin
        dirty_reg <= 1'b1;
      end
    end
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LATCH;
      lat_reg   <= CNT_W'(NRES);
      cyc_reg   <= '0;
      bit_reg   <= '0;
      led_reg   <= '0;
      data_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          data_reg <= 1'b0;
          if (go) begin
            state_reg <= SEND;
            cyc_reg   <= '0;
            bit_reg   <= BIT_W'(BITS_PER_LED - 1);
            led_reg   <= '0;
            data_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            frame_reg <= 1'b1;
          end
        end

        SEND: begin
          cyc_reg  <= cyc_next;
          data_reg <= send_level;
          if (last_cyc) begin
            if (last_bit) begin
              bit_reg <= BIT_W'(BITS_PER_LED - 1);
              if (last_led) begin
                state_reg <= LATCH;
                lat_reg   <= CNT_W'(NRES);
                data_reg  <= 1'b0;
                done_reg  <= (NRES == 1);
              end else begin
                led_reg <= led_reg + 1'b1;
              end
            end else begin
              bit_reg <= bit_reg - 1'b1;
            end
          end
        end

        LATCH: begin
          data_reg <= 1'b0;
          lat_reg  <= lat_reg - 1'b1;
          // Pulse lands on the final latch cycle; the gap that follows a
          // reset carries no frame and so produces no pulse.
          done_reg <= frame_reg && (lat_reg == CNT_W'(2));
          if (lat_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            frame_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= LATCH;
          lat_reg   <= CNT_W'(NRES);
          data_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_ws2812_strip.sv
// tb_ws2812_strip
//   Randomized bench for ws2812_strip at 10 MHz, 2 LEDs, 24 bits, 1 us latch.
//   A one-shot instance has its waveform decoded bit by bit against a
//   two-bank pixel model; a free-running instance shares the inputs and is
//   checked for frame cadence.
module tb_ws2812_strip;
  localparam int NL   = 2;
  localparam int NBIT = 13;
  localparam int NRES = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [7:0]  led_num;
  logic [23:0] led_data;
  logic        start;
  logic        data, busy, frame_done;
  logic        data_c, busy_c, frame_done_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ws2812_strip #(
    .NUM_LEDS(2), .BITS_PER_LED(24), .CLK_MHZ(10), .T1H_NS(900),
    .T0H_NS(350), .TBIT_NS(1250), .TRES_US(1), .CONTINUOUS(0)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .led_num(led_num),
    .led_data(led_data), .start(start), .data(data), .busy(busy),
    .frame_done(frame_done)
  );

  ws2812_strip #(
    .NUM_LEDS(2), .BITS_PER_LED(24), .CLK_MHZ(10), .T1H_NS(900),
    .T0H_NS(350), .TBIT_NS(1250), .TRES_US(1), .CONTINUOUS(1)
  ) dut_c (
    .clk(clk), .reset(reset), .write(write), .led_num(led_num),
    .led_data(led_data), .start(start), .data(data_c), .busy(busy_c),
    .frame_done(frame_done_c)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: two pixel banks, the one being sent and the one the
  // host writes; a frame start exchanges them if anything was written.
  logic [23:0] bank_m [2][NL];
  int          fsel_m;
  bit          dirty_m;
  logic [23:0] exp_p0, exp_p1;
  int          frame_no = 0;

  function automatic void m_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NL; i++) bank_m[b][i] = '0;
    fsel_m  = 0;
    dirty_m = 1'b0;
  endfunction

  function automatic void m_write(input int n, input logic [23:0] d);
    if (n < NL) begin
      bank_m[1 - fsel_m][n] = d;
      dirty_m = 1'b1;
    end
  endfunction

  function automatic void m_start();
    if (dirty_m) begin
      fsel_m  = 1 - fsel_m;
      dirty_m = 1'b0;
    end
    exp_p0 = bank_m[fsel_m][0];
    exp_p1 = bank_m[fsel_m][1];
  endfunction

  task automatic wr(input int n, input logic [23:0] d);
    write    = 1'b1;
    led_num  = 8'(n);
    led_data = d;
    @(posedge clk); #1;
    write = 1'b0;
    m_write(n, d);
  endtask

  // Pulse start (optionally with a write in the same cycle); returns in
  // the first cycle of the frame.
  task automatic do_start(input bit with_wr, input int n, input logic [23:0] d);
    start = 1'b1;
    if (with_wr) begin
      write    = 1'b1;
      led_num  = 8'(n);
      led_data = d;
      m_write(n, d);
    end
    m_start();
    @(posedge clk); #1;
    start = 1'b0;
    write = 1'b0;
  endtask

  // Decode one whole frame plus latch gap from the one-shot instance.
  task automatic capture_frame(input logic [23:0] p0, input logic [23:0] p1);
    int          busy_n = 0;
    int          done_n = 0;
    logic [12:0] got_v, exp_v;
    logic [23:0] pix [NL];
    pix[0] = p0;
    pix[1] = p1;
    for (int l = 0; l < NL; l++) begin
      for (int b = 23; b >= 0; b--) begin
        got_v = '0;
        exp_v = '0;
        for (int c = 0; c < NBIT; c++) begin
          @(negedge clk);
          got_v[12 - c] = data;
          exp_v[12 - c] = (c < (pix[l][b] ? 9 : 4));
          busy_n += int'(busy);
          done_n += int'(frame_done);
        end
        check_val($sformatf("bit_l%0d_b%0d", l, b), 32'(got_v), 32'(exp_v));
      end
    end
    for (int i = 0; i < NRES; i++) begin
      @(negedge clk);
      check_val("latch_low", 32'(data), 32'd0);
      check_val($sformatf("done_at_%0d", i), 32'(frame_done), 32'(i == NRES - 1));
      busy_n += int'(busy);
      done_n += int'(frame_done);
    end
    @(negedge clk);
    check_val("busy_end", 32'(busy), 32'd0);
    check_val("busy_len", 32'(busy_n), 32'(2 * 24 * NBIT + NRES));
    check_val("done_cnt", 32'(done_n), 32'd1);
    $display("frame %0d: led0=%06h led1=%06h busy=%0d done=%0d",
             frame_no, p0, p1, busy_n, done_n);
    frame_no++;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_data", 32'(data), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  // Cadence monitor for the free-running instance.
  int  cyc_n = 0;
  int  c_last_rise = -1;
  int  c_last_done = -1;
  int  c_rises = 0;
  bit  c_prev = 1'b0;
  always @(negedge clk) begin
    cyc_n++;
    if (reset) begin
      c_last_rise = -1;
      c_last_done = -1;
      c_rises     = 0;
      c_prev      = 1'b0;
    end else begin
      if (data_c && !c_prev) begin
        if (c_last_rise >= 0)
          check_val("cont_rise_gap", 32'(cyc_n - c_last_rise),
                    32'((c_rises == 0) ? NBIT + NRES + 1 : NBIT));
        c_last_rise = cyc_n;
        c_rises++;
      end
      if (frame_done_c) begin
        check_val("cont_bits", 32'(c_rises), 32'd48);
        if (c_last_done >= 0)
          check_val("cont_period", 32'(cyc_n - c_last_done),
                    32'(2 * 24 * NBIT + NRES + 1));
        c_last_done = cyc_n;
        c_rises     = 0;
      end
      c_prev = data_c;
    end
  end

  int          nw, wd, ws;
  logic [23:0] rd;

  initial begin
    reset = 1'b1; write = 1'b0; led_num = '0; led_data = '0; start = 1'b0;
    m_reset();
    repeat (3) begin
      @(negedge clk);
      check_val("rst_data", 32'(data), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(frame_done), 32'd0);
      check_val("rst_data_c", 32'(data_c), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_check(NRES + 4);

    // Single MSB set in LED0; mid-frame write to LED1 and a start while busy.
    wr(0, 24'h800000);
    do_start(1'b0, 0, '0);
    fork
      capture_frame(exp_p0, exp_p1);
      begin
        repeat (300) @(posedge clk); #1;
        wr(1, 24'hFFFFFF);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    idle_check(4);

    // Next frame shows the swapped bank, then an unchanged resend.
    do_start(1'b0, 0, '0);
    capture_frame(exp_p0, exp_p1);
    idle_check(3);
    do_start(1'b0, 0, '0);
    capture_frame(exp_p0, exp_p1);
    idle_check(3);

    // Out-of-range write alone must not dirty or alter anything.
    wr(5, 24'h123456);
    do_start(1'b0, 0, '0);
    capture_frame(exp_p0, exp_p1);
    idle_check(3);

    // Randomized rounds: pre-writes, write with start, mid-frame activity.
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) wr($urandom_range(0, 4), 24'($urandom));
      ws = $urandom_range(0, 1);
      rd = 24'($urandom);
      do_start(ws[0], $urandom_range(0, 2), rd);
      wd = $urandom_range(5, 400);
      fork
        capture_frame(exp_p0, exp_p1);
        begin
          repeat (wd) @(posedge clk); #1;
          wr($urandom_range(0, 4), 24'($urandom));
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      join
      idle_check(4);
    end

    // Reset during bit 10 of LED0.
    wr(0, 24'hA5A5A5);
    do_start(1'b0, 0, '0);
    repeat (10 * NBIT + 5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_mid_data", 32'(data), 32'd0);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_data_c", 32'(data_c), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_val("rst_mid_done", 32'(frame_done), 32'd0);
    end
    write = 1'b1; led_num = 8'd0; led_data = 24'hABCDEF;
    @(posedge clk); #1;
    write = 1'b0;
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < NRES; i++) begin
      @(negedge clk);
      check_val("gap_data", 32'(data), 32'd0);
      check_val("gap_busy", 32'(busy), 32'd0);
      check_val("gap_done", 32'(frame_done), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    do_start(1'b0, 0, '0);
    capture_frame(exp_p0, exp_p1);
    idle_check(3);

    // Leave time for the free-running instance to complete more frames.
    repeat (2 * (2 * 24 * NBIT + NRES + 1)) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
